// File: rtl/sp_ram_banked_wrap.sv
// sp_ram_banked_wrap
// Multi-bank single-port RAM wrapper for the core memory path. The word
// address space is split into NUM_BANKS equal banks selected by the top
// word-address bits. After reset an init sequencer can zero every bank in
// parallel, one row per cycle. Requests use a grant/valid handshake with
// read-first write semantics, an optional output register stage and a
// bypass mode that leaves memory untouched and echoes the write data.
//
// Ports:
//   clk          clock, rising edge
//   rstn_i       asynchronous active-low reset
//   en_i         request
//   addr_i       byte address (low byte-offset bits ignored)
//   wdata_i      write data
//   we_i         1 = write, 0 = read
//   be_i         byte enables for writes
//   bypass_en_i  bypass mode: suppress the write, return wdata_i
//   gnt_o        request accepted this cycle
//   rvalid_o     response valid
//   rdata_o      response data (holds last value while rvalid_o is low)
//   init_done_o  zero-init sequence finished

module sp_ram_banked_wrap #(
    parameter int RAM_SIZE   = 32768,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BANKS  = 4,
    parameter int OUT_REG    = 0,
    parameter int INIT_ZERO  = 1,
    parameter int ADDR_WIDTH = $clog2(RAM_SIZE)
) (
    input  logic                    clk,
    input  logic                    rstn_i,
    input  logic                    en_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic                    bypass_en_i,
    output logic                    gnt_o,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    init_done_o
);

    localparam int WORD_BYTES = DATA_WIDTH / 8;
    localparam int OFFS       = $clog2(WORD_BYTES);
    localparam int WORD_AW    = ADDR_WIDTH - OFFS;
    localparam int BANK_BITS  = $clog2(NUM_BANKS);
    localparam int BANK_SEL_W = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int BANK_WORDS = RAM_SIZE / WORD_BYTES / NUM_BANKS;
    localparam int ROW_AW     = $clog2(BANK_WORDS);
    localparam logic [ROW_AW-1:0] ROW_LAST = ROW_AW'(BANK_WORDS - 1);
    localparam logic DO_ZERO  = (INIT_ZERO != 0);

    typedef enum logic {INIT, READY} state_e;

    state_e                  state_q;
    logic [ROW_AW-1:0]       rowCnt_q;
    logic                    initWr;
    logic                    gnt;
    logic [WORD_AW-1:0]      wordIdx;
    logic [ROW_AW-1:0]       rowIdx;
    logic [BANK_SEL_W-1:0]   bankIdx;

    logic                    valid1_q;
    logic                    haveResp_q;
    logic                    bypass1_q;
    logic [BANK_SEL_W-1:0]   bankSel1_q;
    logic [DATA_WIDTH-1:0]   wdata1_q;
    logic [DATA_WIDTH-1:0]   respData;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bankRdAll;

    assign wordIdx = addr_i[ADDR_WIDTH-1:OFFS];
    assign rowIdx  = wordIdx[ROW_AW-1:0];

    if (NUM_BANKS > 1) begin : g_bankSel
        assign bankIdx = wordIdx[WORD_AW-1:ROW_AW];
    end else begin : g_singleBank
        assign bankIdx = '0;
    end

    if (OFFS > 0) begin : g_offs
        logic unusedAddrBits;
        assign unusedAddrBits = ^addr_i[OFFS-1:0];
    end

    // Init sequencer: INIT walks the row counter across all banks at once
    // (or lasts a single cycle when zero-fill is disabled), then parks in
    // READY until the next reset. The counter is left at 0 for a clean
    // restart on the next reset.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= INIT;
            rowCnt_q <= '0;
        end else begin
            case (state_q)
                INIT: begin
                    if (!DO_ZERO) begin
                        state_q <= READY;
                    end else if (rowCnt_q == ROW_LAST) begin
                        state_q  <= READY;
                        rowCnt_q <= '0;
                    end else begin
                        rowCnt_q <= rowCnt_q + 1'b1;
                    end
                end
                READY: state_q <= READY;
                default: state_q <= INIT;
            endcase
        end
    end

    assign initWr      = DO_ZERO && (state_q == INIT);
    assign gnt         = en_i && (state_q == READY);
    assign gnt_o       = gnt;
    assign init_done_o = (state_q == READY);

    // One storage array per bank. Only the addressed bank is enabled; its
    // read register captures the pre-write word (read-first), which is also
    // what a normal write returns as its response.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [BANK_WORDS];
        logic [DATA_WIDTH-1:0] rdWord_q;
        logic                  bankEn;

        assign bankEn = gnt && (bankIdx == BANK_SEL_W'(b));

        always_ff @(posedge clk) begin
            if (initWr) begin
                mem[rowCnt_q] <= '0;
            end else if (bankEn) begin
                rdWord_q <= mem[rowIdx];
                if (we_i && !bypass_en_i) begin
                    for (int i = 0; i < WORD_BYTES; i++) begin
                        if (be_i[i]) begin
                            mem[rowIdx][i*8 +: 8] <= wdata_i[i*8 +: 8];
                        end
                    end
                end
            end
        end

        assign bankRdAll[b] = rdWord_q;
    end

    // Response stage 1: remember which bank answers and whether the reply is
    // the bypassed write data. These only change on a grant, so the response
    // mux naturally holds the last reply while no request is in flight.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            valid1_q   <= 1'b0;
            haveResp_q <= 1'b0;
            bypass1_q  <= 1'b0;
            bankSel1_q <= '0;
            wdata1_q   <= '0;
        end else begin
            valid1_q <= gnt;
            if (gnt) begin
                haveResp_q <= 1'b1;
                bypass1_q  <= we_i && bypass_en_i;
                bankSel1_q <= bankIdx;
                wdata1_q   <= wdata_i;
            end
        end
    end

    // Bank read registers carry no reset, so the reply reads as zero until
    // the first request after reset has been answered.
    always_comb begin
        respData = '0;
        if (haveResp_q) begin
            respData = bypass1_q ? wdata1_q : bankRdAll[bankSel1_q];
        end
    end

    if (OUT_REG != 0) begin : g_outReg
        logic                  rvalid2_q;
        logic [DATA_WIDTH-1:0] rdata2_q;

        // Extra output stage: one more cycle of latency, same ordering.
        always_ff @(posedge clk or negedge rstn_i) begin
            if (!rstn_i) begin
                rvalid2_q <= 1'b0;
                rdata2_q  <= '0;
            end else begin
                rvalid2_q <= valid1_q;
                if (valid1_q) begin
                    rdata2_q <= respData;
                end
            end
        end

        assign rvalid_o = rvalid2_q;
        assign rdata_o  = rdata2_q;
    end else begin : g_noOutReg
        assign rvalid_o = valid1_q;
        assign rdata_o  = respData;
    end

endmodule
